pipelined_adder: RTL and testbench



---
 rtl/pipelined_adder_pkg.sv | 22 ++
 rtl/adder_seg.sv | 22 ++
 rtl/pipelined_adder.sv | 113 +++++++++++
 tb/tb_pipelined_adder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared helpers and stage control bundle
// for the segmented pipelined adder.
package pipelined_adder_pkg;

   function automatic bit div_ok(input int n, input int s);
      return (s > 0) && (n % s == 0);
   endfunction

   // A bad N/STAGES pair yields a zero segment width.
   // This makes elaboration fail instead of building a wrong adder.
   function automatic int seg_w(input int n, input int s);
      return div_ok(n, s) ? n / s : 0;
   endfunction

   typedef struct packed {
      logic valid;
      logic sub;
      logic cy;
      logic ov;
   } stage_ctl_t;

endpackage

// File: rtl/adder_seg.sv
// adder_seg: one W-bit combinational segment of the pipelined adder.
// Also exposes the carry into its MSB for signed overflow detection.
module adder_seg
   import pipelined_adder_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co,
   output logic         cm
);

   // Segment sum; MSB carry-in recovered from MSB sum bit.
   always_comb begin
      {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      cm      = a[W-1] ^ b[W-1] ^ s[W-1];
   end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: N-bit add split into STAGES registered segments.
// PIPELINED_ADDER_SUB_EN adds a per-operation subtract port (sub).
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int N      = 16,
   parameter int STAGES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
`ifdef PIPELINED_ADDER_SUB_EN
   input  logic         sub,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int SEG = seg_w(N, STAGES);

   typedef struct packed {
      stage_ctl_t   c;
      logic [N-1:0] s;
      logic [N-1:0] a;
      logic [N-1:0] b;
   } payload_t;

   logic     stall;
   logic     sub_i;
   payload_t src0;
   logic     unused_tail;

`ifdef PIPELINED_ADDER_SUB_EN
   assign sub_i = sub;
`else
   assign sub_i = 1'b0;
`endif

   // Entry payload; subtract folds into the stage-0 carry-in.
   always_comb begin
      src0         = '0;
      src0.c.valid = in_valid;
      src0.c.sub   = sub_i;
      src0.c.cy    = cin ^ sub_i;
      src0.a       = a;
      src0.b       = b;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      payload_t       d;
      payload_t       nx;
      payload_t       q;
      logic [SEG-1:0] ss;
      logic           co;
      logic           cm;

      if (k == 0) begin : g_src
         assign d = src0;
      end else begin : g_src
         assign d = g_stg[k-1].q;
      end

      adder_seg #(.W(SEG)) u_seg (
         .a  (d.a[k*SEG +: SEG]),
         .b  (d.b[k*SEG +: SEG] ^ {SEG{d.c.sub}}),
         .ci (d.c.cy),
         .s  (ss),
         .co (co),
         .cm (cm)
      );

      // Merge this segment's result into the travelling payload.
      always_comb begin
         nx                   = d;
         nx.s[k*SEG +: SEG]   = ss;
         nx.c.cy              = co;
         nx.c.ov              = cm ^ co;
      end

      // Stage register: hold on stall, keep data across bubbles.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            q <= '0;
         end else if (!stall) begin
            if (d.c.valid) begin
               q <= nx;
            end else begin
               q.c.valid <= 1'b0;
            end
         end
      end
   end

   assign out_valid = g_stg[STAGES-1].q.c.valid;
   assign sum       = g_stg[STAGES-1].q.s;
   assign cout      = g_stg[STAGES-1].q.c.cy;
   assign ovf       = g_stg[STAGES-1].q.c.ov;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   assign unused_tail = ^{g_stg[STAGES-1].q.a,
                          g_stg[STAGES-1].q.b,
                          g_stg[STAGES-1].q.c.sub};

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed vectors, whole-word reference model
// and a per-cycle scoreboard for pipelined_adder.
module tb_pipelined_adder;
   import pipelined_adder_pkg::*;

   localparam int N      = 16;
   localparam int STAGES = 4;

   typedef logic [N+1:0] res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] sum;
   logic         cout;
   logic         ovf;

   int   errors = 0;
   int   checks = 0;
   int   n_in   = 0;
   int   n_out  = 0;
   res_t q[$];

   logic [N-1:0] sa [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F,
                            16'hAAAA, 16'h0001, 16'h7FFF, 16'h00F0};
   logic [N-1:0] sb [8] = '{16'h4321, 16'hFFFF, 16'h8000, 16'hF0F1,
                            16'h5555, 16'hFFFF, 16'h7FFF, 16'h0F10};
   logic         sc [8] = '{1'b0, 1'b1, 1'b0, 1'b0,
                            1'b1, 1'b0, 1'b1, 1'b0};
   res_t         se [8] = '{18'h05555, 18'h1FFFF, 18'h30000, 18'h10000,
                            18'h10000, 18'h10000, 18'h2FFFF, 18'h01000};

   always #5 clk = ~clk;

   if (N % STAGES != 0) begin : g_bad_cfg
      initial begin
         $display("FAIL cfg: N=%0d not divisible by STAGES=%0d", N, STAGES);
         $fatal(1);
      end
   end

   pipelined_adder #(.N(N), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   function automatic res_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                  input logic ci, input logic s);
      logic [N-1:0] be;
      logic         ce;
      logic [N:0]   t;
      logic         ov;
      be = s ? ~y : y;
      ce = s ? ~ci : ci;
      t  = {1'b0, x} + {1'b0, be} + {{N{1'b0}}, ce};
      ov = (x[N-1] == be[N-1]) && (t[N-1] != x[N-1]);
      return {ov, t};
   endfunction

   task automatic check(input string nm, input res_t act, input res_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Scoreboard: compare every valid output against the model queue.
   always @(negedge clk) begin
      check("in_ready_rule", res_t'(in_ready),
            res_t'(!(out_valid && !out_ready)));
      if (rst) begin
         check("rst_valid", res_t'(out_valid), res_t'(0));
         check("rst_sum", res_t'(sum), res_t'(0));
         q.delete();
      end else begin
         if (out_valid) begin
            if (q.size() == 0) begin
               check("spurious_out", res_t'(out_valid), res_t'(0));
            end else begin
               check("sb_result", {ovf, cout, sum}, q[0]);
               if (out_ready) begin
                  void'(q.pop_front());
                  n_out++;
               end
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, cin, sub));
            n_in++;
         end
      end
   end

   task automatic send(input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic ci, input logic s);
      int t;
      t        = 0;
      a        = x;
      b        = y;
      cin      = ci;
      sub      = s;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("send_timeout", res_t'(in_ready), res_t'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic expect_lit(input string nm, input res_t exp);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 50);
      check({nm, "_valid"}, res_t'(out_valid), res_t'(1));
      check(nm, {ovf, cout, sum}, exp);
   endtask

   task automatic drain();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((out_valid || q.size() != 0) && n < 50);
      check("drain_empty", res_t'(q.size()), res_t'(0));
      @(posedge clk);
      #1;
   endtask

   initial begin : safety
      #200000;
      $display("FAIL global_timeout: sim time exceeded");
      $fatal(1);
   end

   initial begin : main
      int   n;
      int   base_in;
      int   base_out;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_cout", res_t'(cout), res_t'(0));
      check("rst_ovf", res_t'(ovf), res_t'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", res_t'(in_ready), res_t'(1));
      @(posedge clk);
      #1;

      // Inter-segment carry and latency.
      send(16'h00FF, 16'h0001, 1'b0, 1'b0);
      in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 20);
      check("latency", res_t'(n), res_t'(STAGES));
      check("lit_carry", {ovf, cout, sum}, 18'h00100);
      @(posedge clk);
      #1;

      send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      in_valid = 1'b0;
      expect_lit("lit_wrap", 18'h10000);
      @(posedge clk);
      #1;

      send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      in_valid = 1'b0;
      expect_lit("lit_ovf", 18'h28000);
      @(posedge clk);
      #1;

      // Eight back-to-back vectors, full throughput.
      fork
         begin
            for (int i = 0; i < 8; i++) send(sa[i], sb[i], sc[i], 1'b0);
            in_valid = 1'b0;
         end
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!out_valid && n < 50);
            for (int i = 0; i < 8; i++) begin
               if (i > 0) @(negedge clk);
               check("stream_valid", res_t'(out_valid), res_t'(1));
               check("stream_val", {ovf, cout, sum}, se[i]);
            end
         end
      join
      drain();

      // Backpressure with a full pipeline.
      out_ready = 1'b0;
      send(16'h1111, 16'h2222, 1'b0, 1'b0);
      send(16'h0101, 16'h0202, 1'b0, 1'b0);
      send(16'h0F0F, 16'h0101, 1'b1, 1'b0);
      send(16'h8001, 16'h8001, 1'b0, 1'b0);
      a        = 16'h1234;
      b        = 16'h0001;
      cin      = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_ready", res_t'(in_ready), res_t'(0));
         check("stall_valid", res_t'(out_valid), res_t'(1));
         check("stall_hold", {ovf, cout, sum}, 18'h03333);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(16'h1234, 16'h0001, 1'b0, 1'b0);
      in_valid = 1'b0;
      drain();
      check("no_loss_dup", res_t'(n_out), res_t'(n_in));

      // Asynchronous reset with results in flight.
      send(16'h0A0A, 16'h0505, 1'b0, 1'b0);
      send(16'h1000, 16'h2000, 1'b1, 1'b0);
      send(16'h4444, 16'h4444, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midrst_valid", res_t'(out_valid), res_t'(0));
      check("midrst_out", {ovf, cout, sum}, 18'h00000);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      base_in  = n_in;
      base_out = n_out;
      send(16'h0F00, 16'h00F0, 1'b0, 1'b0);
      send(16'hFFFE, 16'h0001, 1'b1, 1'b0);
      in_valid = 1'b0;
      expect_lit("post_rst0", 18'h00FF0);
      @(negedge clk);
      check("post_rst1_valid", res_t'(out_valid), res_t'(1));
      check("post_rst1", {ovf, cout, sum}, 18'h10000);
      @(posedge clk);
      #1;
      drain();
      check("post_rst_count", res_t'(n_out - base_out), res_t'(2));
      check("post_rst_in", res_t'(n_in - base_in), res_t'(2));

`ifdef PIPELINED_ADDER_SUB_EN
      // Mixed subtract then add, back-to-back.
      send(16'h0005, 16'h0007, 1'b0, 1'b1);
      send(16'h0005, 16'h0007, 1'b0, 1'b0);
      in_valid = 1'b0;
      sub      = 1'b0;
      expect_lit("sub_lit", 18'h0FFFE);
      @(negedge clk);
      check("add_after_sub_valid", res_t'(out_valid), res_t'(1));
      check("add_after_sub", {ovf, cout, sum}, 18'h0000C);
      @(posedge clk);
      #1;
      drain();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
